ddr_tx_lane_packer: RTL



---
 rtl/ddr_tx_lane_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ddr_tx_lane_packer.sv
// rtl/ddr_tx_lane_packer.sv - repacks 4x5 demux sample groups into 2x10 OSERDES lane slots with link framing
//
// Optional feature macro: DDR_TX_TESTPAT_EN (adds test_mode port and ramp payload source)
//
// Ports:
//   clk80          in   parallel clock, the only clock
//   reset          in   asynchronous, active-high
//   demux_data     in   [t][ch] samples, t=0 oldest; sample n = 5*t + ch
//   in_valid       in   demux_data holds a new 20-sample group
//   train_req      in   level request to (re)enter training
//   test_mode      in   ramp source select (DDR_TX_TESTPAT_EN only)
//   lane_data      out  [lane][slot] to the serializers, slot 0 first; lane l slot k = sample 2k+l
//   link_up        out  word carries payload/idle
//   frame_start    out  pulse on the first word of each frame
//   underrun_count out  DATA cycles with no input group, saturating
module ddr_tx_lane_packer #(
  parameter int WIDTH        = 14,
  parameter int TRAIN_CYCLES = 64,
  parameter int FRAME_LEN    = 1024
) (
  input  logic                          clk80,
  input  logic                          reset,
  input  logic [3:0][4:0][WIDTH-1:0]    demux_data,
  input  logic                          in_valid,
  input  logic                          train_req,
`ifdef DDR_TX_TESTPAT_EN
  input  logic                          test_mode,
`endif
  output logic [1:0][9:0][WIDTH-1:0]    lane_data,
  output logic                          link_up,
  output logic                          frame_start,
  output logic [15:0]                   underrun_count
);

  localparam int TC_W = $clog2(TRAIN_CYCLES);
  localparam int FL_W = $clog2(FRAME_LEN);
  localparam logic [TC_W-1:0] TRAIN_LAST = TC_W'(TRAIN_CYCLES - 1);
  localparam logic [FL_W-1:0] FRAME_LAST = FL_W'(FRAME_LEN - 1);

  // Alternating bits with LSB set gives the receiver a dense edge pattern for bit alignment.
  function automatic logic [WIDTH-1:0] alt_pattern();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = (i % 2 == 0);
    return r;
  endfunction

  localparam logic [WIDTH-1:0] TRAIN_A = alt_pattern();
  localparam logic [WIDTH-1:0] TRAIN_B = ~TRAIN_A;
  localparam logic [WIDTH-1:0] ONES    = '1;
  // Upper ceil(WIDTH/2) bits set: a single transition per word marks the word boundary.
  localparam logic [WIDTH-1:0] SYNC    = ~(ONES >> ((WIDTH + 1) / 2));

  typedef enum logic [1:0] {ST_TRAIN, ST_SYNC, ST_DATA} state_t;

  state_t                       state;
  logic [TC_W-1:0]              train_cnt;
  logic [FL_W-1:0]              frame_cnt;
  logic [1:0][9:0][WIDTH-1:0]   packed_word;
  logic [1:0][9:0][WIDTH-1:0]   train_word;
  logic [1:0][9:0][WIDTH-1:0]   sync_word;

`ifdef DDR_TX_TESTPAT_EN
  logic [WIDTH-1:0]             base;
  logic [1:0][9:0][WIDTH-1:0]   ramp_word;
`endif

  // Static slot mapping: lane l, slot k carries sample n = 2k + l, i.e. demux_data[n/5][n%5].
  for (genvar k = 0; k < 10; k++) begin : g_slot
    for (genvar l = 0; l < 2; l++) begin : g_lane
      localparam int N = 2 * k + l;
      assign packed_word[l][k] = demux_data[N / 5][N % 5];
      assign train_word[l][k]  = (k % 2 == 0) ? TRAIN_A : TRAIN_B;
      assign sync_word[l][k]   = SYNC;
`ifdef DDR_TX_TESTPAT_EN
      assign ramp_word[l][k]   = base + WIDTH'(N);
`endif
    end
  end

  always_ff @(posedge clk80 or posedge reset) begin
    if (reset) begin
      state          <= ST_TRAIN;
      train_cnt      <= '0;
      frame_cnt      <= '0;
      lane_data      <= '0;
      link_up        <= 1'b0;
      frame_start    <= 1'b0;
      underrun_count <= '0;
`ifdef DDR_TX_TESTPAT_EN
      base           <= '0;
`endif
    end else begin
      case (state)
        ST_TRAIN: begin
          lane_data   <= train_word;
          link_up     <= 1'b0;
          frame_start <= 1'b0;
          // A pending request wins over the terminal count and restarts the minimum training time.
          if (train_req) begin
            train_cnt <= '0;
          end else if (train_cnt == TRAIN_LAST) begin
            train_cnt <= '0;
            state     <= ST_SYNC;
          end else begin
            train_cnt <= train_cnt + 1'b1;
          end
        end

        ST_SYNC: begin
          lane_data   <= sync_word;
          link_up     <= 1'b0;
          frame_start <= 1'b0;
          frame_cnt   <= '0;
`ifdef DDR_TX_TESTPAT_EN
          base        <= '0;
`endif
          state       <= ST_DATA;
        end

        ST_DATA: begin
          link_up     <= 1'b1;
          frame_start <= (frame_cnt == '0);
          frame_cnt   <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
`ifdef DDR_TX_TESTPAT_EN
          base        <= base + WIDTH'(20);
          if (test_mode) begin
            lane_data <= ramp_word;
          end else
`endif
          if (in_valid) begin
            lane_data <= packed_word;
          end else begin
            lane_data <= '0;
            if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
          end
          // The word produced this cycle is still payload; training starts on the next edge.
          if (train_req) begin
            train_cnt <= '0;
            state     <= ST_TRAIN;
          end
        end

        default: begin
          state <= ST_TRAIN;
        end
      endcase
    end
  end

endmodule
